// File: rtl/ndro_bank.sv
// Multi-channel NDRO storage bank with init period, hold-window checks and sticky violation flags.
// Optional NDRO_VIOL_CNT_EN adds a saturating violation-cycle counter on port viol_cnt.
module ndro_bank #(
    parameter int CH          = 4,
    parameter int HOLD_CYC    = 2,
    parameter int INIT_CYC    = 8,
    parameter bit DESTRUCTIVE = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] set_tg,
    input  logic [CH-1:0] clr_tg,
    input  logic [CH-1:0] rd_tg,
    input  logic          viol_clr,
    output logic [CH-1:0] out,
    output logic          ready,
    output logic [CH-1:0] viol
`ifdef NDRO_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam int IW = (INIT_CYC > 0) ? $clog2(INIT_CYC + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic [1:0] {UNINIT, S0, S1} ch_state_t;

    if (CH < 1 || CNT_W < 1 || HOLD_CYC < 0 || INIT_CYC < 0) begin : g_bad_param
        $error("ndro_bank: illegal parameter value");
    end

    logic [CH-1:0] set_q, clr_q, rd_q;
    logic [CH-1:0] set_p, clr_p, rd_p;
    logic [CH-1:0] set_v, clr_v, new_viol;
    logic [CH-1:0] out_nx;
    logic [IW-1:0] init_cnt;
    logic          init_hit;

    ch_state_t     state      [CH];
    ch_state_t     state_nx   [CH];
    logic [HW-1:0] clr_hold   [CH];
    logic [HW-1:0] clr_hold_nx[CH];
    logic [HW-1:0] rd_hold    [CH];
    logic [HW-1:0] rd_hold_nx [CH];

    // Toggle-encoded lines: any change since the last sample is one pulse.
    assign set_p = set_tg ^ set_q;
    assign clr_p = clr_tg ^ clr_q;
    assign rd_p  = rd_tg ^ rd_q;

    assign init_hit = (int'(init_cnt) + 1) >= INIT_CYC;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        out_nx = out;
        for (int i = 0; i < CH; i++) begin
            logic active, clr_ok, set_ok, rd_ok;
            active = (state[i] != UNINIT);
            set_v[i] = active && set_p[i] && ((clr_hold[i] != '0) || clr_p[i]);
            clr_v[i] = (state[i] == S1) && clr_p[i] && ((rd_hold[i] != '0) || rd_p[i]);
            clr_ok   = active && clr_p[i] && !clr_v[i];
            set_ok   = (state[i] == S0) && set_p[i] && !set_v[i];
            rd_ok    = (state[i] == S1) && rd_p[i];

            state_nx[i] = state[i];
            case (state[i])
                UNINIT:  if (init_hit) state_nx[i] = S0;
                S0:      if (set_ok) state_nx[i] = S1;
                S1:      if (clr_ok || (rd_ok && DESTRUCTIVE)) state_nx[i] = S0;
                default: state_nx[i] = UNINIT;
            endcase

            out_nx[i] = out[i] ^ rd_ok;

            if (clr_ok)
                clr_hold_nx[i] = HOLD_LD;
            else if (clr_hold[i] != '0)
                clr_hold_nx[i] = clr_hold[i] - HW'(1);
            else
                clr_hold_nx[i] = '0;

            // In DRO mode the channel leaves S1 on a read, so the read window never matters.
            if (rd_ok && !DESTRUCTIVE)
                rd_hold_nx[i] = HOLD_LD;
            else if (rd_hold[i] != '0)
                rd_hold_nx[i] = rd_hold[i] - HW'(1);
            else
                rd_hold_nx[i] = '0;
        end
    end

    assign new_viol = set_v | clr_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_q <= '0;
            clr_q <= '0;
            rd_q  <= '0;
        end else begin
            set_q <= set_tg;
            clr_q <= clr_tg;
            rd_q  <= rd_tg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt <= '0;
            ready    <= 1'b0;
        end else if (!ready) begin
            if (init_hit)
                ready <= 1'b1;
            else
                init_cnt <= init_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                state[i]    <= UNINIT;
                clr_hold[i] <= '0;
                rd_hold[i]  <= '0;
            end
            out  <= '0;
            viol <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state[i]    <= state_nx[i];
                clr_hold[i] <= clr_hold_nx[i];
                rd_hold[i]  <= rd_hold_nx[i];
            end
            out  <= out_nx;
            // A violation detected in the same cycle as viol_clr keeps its flag.
            viol <= (viol & ~{CH{viol_clr}}) | new_viol;
        end
    end

`ifdef NDRO_VIOL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            viol_cnt <= '0;
        else if ((|new_viol) && (viol_cnt != '1))
            viol_cnt <= viol_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: doc/ndro_bank.md
Name: ndro_bank

Overview:
- Parametrised multi-channel non-destructive readout (NDRO) storage bank, behavioural model for pulse-logic verification.
- Pulse lines are toggle-encoded: each transition is one pulse. All lines are sampled on a single system clock.
- Each channel holds one bit, set and cleared by pulses. A read pulse toggles that channel's output when the bit is 1.
- Adds an init period, per-channel hold-window checking with sticky violation flags, and an optional destructive-read mode.

Parameters:
- CH, 4: number of channels.
- HOLD_CYC, 2: hold window in clk cycles. Value 0 checks same-cycle conflicts only.
- INIT_CYC, 8: cycles after reset release during which all pulses are ignored.
- DESTRUCTIVE, 0: 1 makes a valid read also clear the channel (DRO mode).
- CNT_W, 8: violation counter width (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- set_tg  in  CH  set pulse lines, toggle-encoded.
- clr_tg  in  CH  clear pulse lines, toggle-encoded.
- rd_tg  in  CH  read pulse lines, toggle-encoded.
- viol_clr  in  1  synchronous level; clears all violation flags.
- out  out  CH  readout lines; toggle on each valid read.
- ready  out  1  high once INIT_CYC has elapsed.
- viol  out  CH  sticky per-channel hold-violation flags.

Behaviour:
- Pulse detect:
  - Per-line previous-sample register, reset to 0.
  - pulse = line != previous sample at that rising edge.
  - All resulting updates take effect at that same edge, so there is 1-edge latency from line change to output.
- Reset (reset=0, asynchronous):
  - out=0, viol=0, ready=0.
  - Every channel goes to UNINIT; init counter=0; hold counters=0; previous samples=0.
- Init:
  - Init counter increments each cycle after reset release.
  - When it reaches INIT_CYC: ready=1 and all channels go UNINIT->S0.
  - Pulses sampled while UNINIT are ignored and raise no violations. This includes spurious pulses from lines that were high at reset.
- Per-channel FSM:
  - UNINIT: waits for init.
  - S0, set pulse: go to S1 (unless violating).
  - S0, clr pulse: no-op, but loads the clear-hold counter.
  - S0, rd pulse: no-op; out is unchanged.
  - S1, rd pulse: out toggles. If DESTRUCTIVE=1, go to S0; otherwise stay in S1 and load the read-hold counter.
  - S1, clr pulse: go to S0 (unless violating); loads the clear-hold counter.
  - S1, set pulse: no-op.
- Hold windows:
  - Clear-hold counter: loaded with HOLD_CYC on any accepted clr pulse, decrements to 0.
  - Read-hold counter: loaded with HOLD_CYC on a valid read in S1, decrements to 0.
- Violation rules:
  - Set violation: a set pulse when the clear-hold counter is nonzero, or coincident with a clr pulse. The set is ignored.
  - Clear violation: in S1, a clr pulse when the read-hold counter is nonzero, or coincident with an rd pulse. The clr is ignored; the rd is still processed.
- Simultaneous set+clr:
  - In S0: channel stays S0; viol set.
  - In S1: clr processed -> S0; set ignored; viol set.
- Violation flags:
  - viol[i] is set at the edge where the violation is detected.
  - It holds until reset or viol_clr.
  - viol_clr coincident with a new violation: the new violation wins (flag stays 1).
- Reset mid-operation: takes immediate effect. The full init period repeats after release.

Optional Feature:
- Macro NDRO_VIOL_CNT_EN.
- Defined:
  - Adds output port viol_cnt (CNT_W bits), reset to 0.
  - Increments by 1 on each cycle in which at least one new violation is detected on any channel.
  - Saturates at all-ones.
  - Not cleared by viol_clr.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Init: reset low 3 cycles, release, toggle set_tg[0] at cycle 2 -> ignored; ready rises at cycle 8; out=0, viol=0.
- NDRO read: after ready, set_tg[1] toggle, then rd_tg[1] toggled 3 times 4 cycles apart -> out[1] toggles each time (1,0,1); channel stays S1.
- Read in S0: rd_tg[2] toggle on cleared channel -> out[2] unchanged, viol[2]=0.
- Hold violation, HOLD_CYC=2:
  - ch0 in S0: clr pulse at cycle t, set pulse at t+1 -> viol[0]=1, channel stays S0.
  - Repeat with set at t+3 -> accepted, no new violation.
- Coincident events in S1:
  - rd+clr same cycle -> out toggles, stays S1, viol=1.
  - DESTRUCTIVE=1 build: rd alone -> out toggles and channel goes to S0; a second rd produces no toggle.
- Counter (NDRO_VIOL_CNT_EN, CNT_W=2): 5 violation cycles -> viol_cnt=3 (saturated); viol_clr clears viol, viol_cnt remains 3; async reset mid-test -> all outputs 0 immediately.
